piped_alu_fwd: RTL and testbench
================================

# piped_alu_fwd

Parametrised three-stage pipelined ALU with an internal register bank, operand forwarding, per-instruction valid tracking and result flags. Next generation of the team's 8-bit pipelined ALU: data width and register count are parameters, and back-to-back dependent instructions get correct operands without software-inserted bubbles. It is the execute core for the small sequencer datapath, fed one instruction per cycle.

## Interface
- DATA_W, 8: operand/result width, ≥ 4.
- NREG, 8: register-bank entries, power of two, ≥ 2.
- ADDR_W, $clog2(NREG): register index width (derived, not overridden).
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  instruction present this cycle.
- rs1  input  ADDR_W  source register A.
- rs2  input  ADDR_W  source register B.
- rd  input  ADDR_W  destination register.
- opcode  input  4  operation select.
- Out  output  DATA_W  registered result.
- out_valid  output  1  Out/out_rd/flags hold a completed instruction.
- out_rd  output  ADDR_W  destination of the completed instruction.
- zero_flag  output  1  Out == 0 (qualified by out_valid).
- carry_flag  output  1  see arithmetic rules.

## Operation
- Stage 1 (issue): on the clock edge with in_valid = 1, capture forwarded operands A and B, opcode, rd, and valid = 1. With in_valid = 0, capture valid = 0 (bubble).
- Stage 2 (execute): registers result, flags, rd and valid into Out, carry_flag, zero_flag, out_rd and out_valid.
- Stage 3 (writeback): when out_valid = 1, write regbank[out_rd] <= Out. A bubble performs no write.
- Opcodes, all results truncated to DATA_W:
  - 0 ADD
  - 1 SUB (A−B)
  - 2 MUL (low half)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT A
  - 7 NOT B
  - 8 PASS A
  - 9 PASS B
  - 10 LSR A by 1
  - 11 LSL A by 1
  - 12 ASR A by 1
  - 13 ROL A by 1
- Opcodes 14–15 are illegal and treated as bubbles: out_valid stays 0 for that slot and no write occurs.
- carry_flag rules:
  - ADD: carry out of the MSB.
  - SUB: borrow (A < B unsigned).
  - MUL: 1 if the upper DATA_W bits of the full product are non-zero.
  - LSR/ASR: old A[0].
  - LSL/ROL: old A[DATA_W−1].
  - All other opcodes: 0.
- Forwarding for each source (rs1 and rs2 independently), checked in priority order:
  1. Stage-1 entry is valid, its rd equals the source, and its opcode is legal: take the combinational execute result now being computed.
  2. Else out_valid = 1 and out_rd equals the source: take Out (same-edge writeback).
  3. Else read regbank.
- No register is hardwired to zero.

## Timing
- Throughput: one instruction per cycle, no stalls, no backpressure.
- Latency: an instruction sampled at edge E0 has Out/out_valid valid after E1 and is visible in regbank after E2.
- A dependent instruction may issue at E1 (uses forwarding path 1), at E2 (path 2), or from E3 on (regbank read).
- Reset values (reset sampled high at any edge):
  - Out = 0, out_valid = 0, out_rd = 0, zero_flag = 0, carry_flag = 0.
  - Stage-1 valid = 0 and its operands = 0.
  - All regbank entries = 0.
- Reset mid-operation discards every in-flight instruction. No write occurs at the reset edge, even if out_valid was 1 before it.
- First edge after reset deasserts: in_valid is honoured normally, with the regbank reading all zeros.
- Simultaneous writeback and read of the same register: forwarded Out wins, never the stale regbank value.
- Two in-flight instructions with the same rd: the younger one (stage 1) wins the forward.

## Structure
- Package piped_alu_pkg holds the opcode localparams (OP_ADD … OP_ROL), OP_W = 4, and an is_legal_op function.
- Sub-module alu_core: purely combinational (A, B, opcode → result, carry, zero), parametrised by DATA_W. It is instantiated once in execute; its result output also drives forwarding path 1.
- Register bank is a plain array in the top module: 2 combinational reads, 1 synchronous write.

## Test plan
- Reset, then with DATA_W = 8 issue MOV-style loads in consecutive cycles via PASS of freshly written registers → regbank zeros until E2; Out = 0 and zero_flag = 1 on the first result.
- Preload R1 = 0xF0 and R2 = 0x20 (through prior writes); ADD R3 = R1+R2 → Out = 0x10, carry_flag = 1. SUB R4 = R2−R1 → Out = 0x30, carry_flag = 1.
- Back-to-back chain, one per cycle:
  - R1 = R1+R1 with R1 = 0x03
  - then R2 = R1+R1
  - then R3 = R2+R1
  - Required: Outs 0x06, 0x0C, 0x12 with no bubbles (exercises forwarding paths 1 and 2).
- Two consecutive writes to R5 (0x11, then 0x22) followed by PASS R5 → 0x22.
- Illegal opcode 15 between valid instructions → no out_valid pulse for that slot and the destination register unchanged; assert reset mid-chain → all outputs 0 next cycle and all registers read 0.
- DATA_W = 16, NREG = 16: MUL 0x0100 × 0x0100 → Out = 0x0000, carry_flag = 1, zero_flag = 1; ROL 0x8001 → 0x0003, carry_flag = 1.

Source files
------------

// File: rtl/piped_alu_fwd_pkg.sv
// Shared opcode encoding and helpers for the pipelined ALU with operand forwarding.
package piped_alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd2;
  localparam logic [OP_W-1:0] OP_AND   = 4'd3;
  localparam logic [OP_W-1:0] OP_OR    = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd5;
  localparam logic [OP_W-1:0] OP_NOTA  = 4'd6;
  localparam logic [OP_W-1:0] OP_NOTB  = 4'd7;
  localparam logic [OP_W-1:0] OP_PASSA = 4'd8;
  localparam logic [OP_W-1:0] OP_PASSB = 4'd9;
  localparam logic [OP_W-1:0] OP_LSR   = 4'd10;
  localparam logic [OP_W-1:0] OP_LSL   = 4'd11;
  localparam logic [OP_W-1:0] OP_ASR   = 4'd12;
  localparam logic [OP_W-1:0] OP_ROL   = 4'd13;

  // Encodings above OP_ROL are reserved and execute as bubbles.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/piped_alu_fwd_alu_core.sv
// Purely combinational ALU: result, carry and zero for one operand pair.
module alu_core
  import piped_alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_opcode,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_prod;

  // One extra bit on add/sub captures carry and borrow directly.
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (i_opcode)
      OP_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      OP_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = w_diff[DATA_W];
      end
      OP_MUL: begin
        o_result = w_prod[DATA_W-1:0];
        o_carry  = |w_prod[2*DATA_W-1:DATA_W];
      end
      OP_AND:   o_result = i_a & i_b;
      OP_OR:    o_result = i_a | i_b;
      OP_XOR:   o_result = i_a ^ i_b;
      OP_NOTA:  o_result = ~i_a;
      OP_NOTB:  o_result = ~i_b;
      OP_PASSA: o_result = i_a;
      OP_PASSB: o_result = i_b;
      OP_LSR: begin
        o_result = {1'b0, i_a[DATA_W-1:1]};
        o_carry  = i_a[0];
      end
      OP_LSL: begin
        o_result = {i_a[DATA_W-2:0], 1'b0};
        o_carry  = i_a[DATA_W-1];
      end
      OP_ASR: begin
        o_result = {i_a[DATA_W-1], i_a[DATA_W-1:1]};
        o_carry  = i_a[0];
      end
      OP_ROL: begin
        o_result = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
        o_carry  = i_a[DATA_W-1];
      end
      default: ;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/piped_alu_fwd.sv
// Three-stage pipelined ALU (issue / execute / writeback) with a local register
// bank and two-level operand forwarding so dependent instructions never stall.
module piped_alu_fwd
  import piped_alu_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NREG   = 8,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] Out,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_rd,
  output logic              zero_flag,
  output logic              carry_flag
);

  // Stage-1 (issue) registers
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic [OP_W-1:0]   r_s1_op;
  logic [ADDR_W-1:0] r_s1_rd;

  // Stage-2 (execute) registers
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_rd;
  logic              r_zero;
  logic              r_carry;

  logic [DATA_W-1:0] r_regbank [NREG];

  logic [DATA_W-1:0] w_alu_result;
  logic              w_alu_carry;
  logic              w_alu_zero;
  logic              w_s2_valid;
  logic              w_s1_fwd_ok;
  logic              w_wb_fwd_ok;
  logic [DATA_W-1:0] w_opnd_a;
  logic [DATA_W-1:0] w_opnd_b;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_opcode (r_s1_op),
    .o_result (w_alu_result),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero)
  );

  // An illegal opcode in stage 1 is a bubble: it neither completes nor forwards.
  assign w_s2_valid  = r_s1_valid && is_legal_op(r_s1_op);
  assign w_s1_fwd_ok = w_s2_valid;
  assign w_wb_fwd_ok = r_out_valid;

  // Younger in-flight result beats the one being written back, which beats the bank.
  assign w_opnd_a = (w_s1_fwd_ok && (r_s1_rd  == rs1)) ? w_alu_result :
                    (w_wb_fwd_ok && (r_out_rd == rs1)) ? r_out        :
                                                         r_regbank[rs1];
  assign w_opnd_b = (w_s1_fwd_ok && (r_s1_rd  == rs2)) ? w_alu_result :
                    (w_wb_fwd_ok && (r_out_rd == rs2)) ? r_out        :
                                                         r_regbank[rs2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_rd    <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= w_opnd_a;
        r_s1_b  <= w_opnd_b;
        r_s1_op <= opcode;
        r_s1_rd <= rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
      r_out_valid <= w_s2_valid;
      r_zero      <= w_s2_valid && w_alu_zero;
      r_carry     <= w_s2_valid && w_alu_carry;
      if (w_s2_valid) begin
        r_out    <= w_alu_result;
        r_out_rd <= r_s1_rd;
      end
    end
  end

  // Reset has priority, so a result still sitting in stage 2 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regbank[i] <= '0;
      end
    end else if (r_out_valid) begin
      r_regbank[r_out_rd] <= r_out;
    end
  end

  assign Out        = r_out;
  assign out_valid  = r_out_valid;
  assign out_rd     = r_out_rd;
  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;

endmodule

// File: tb/tb_piped_alu_fwd.sv
// Bench: an 8-bit and a 16-bit instance run the same instruction stream against a
// sequential-semantics reference model (forwarding must make the pipe look sequential).
module tb_piped_alu_fwd;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] opcode;
  logic [2:0] rs1_8, rs2_8, rd_8;
  logic [3:0] rs1_16, rs2_16, rd_16;

  logic [7:0]  out_8;
  logic        out_valid_8, zero_8, carry_8;
  logic [2:0]  out_rd_8;
  logic [15:0] out_16;
  logic        out_valid_16, zero_16, carry_16;
  logic [3:0]  out_rd_16;

  int n_tests = 0;
  int n_fail  = 0;

  longint m8  [8];
  longint m16 [8];
  bit     cur_v;
  int     cur_rd;
  longint cur_r8, cur_r16;
  bit     cur_c8, cur_c16;

  always #5 clk = ~clk;

  piped_alu_fwd #(.DATA_W(8), .NREG(8)) u_dut8 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .rs1        (rs1_8),
    .rs2        (rs2_8),
    .rd         (rd_8),
    .opcode     (opcode),
    .Out        (out_8),
    .out_valid  (out_valid_8),
    .out_rd     (out_rd_8),
    .zero_flag  (zero_8),
    .carry_flag (carry_8)
  );

  piped_alu_fwd #(.DATA_W(16), .NREG(16)) u_dut16 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .rs1        (rs1_16),
    .rs2        (rs2_16),
    .rd         (rd_16),
    .opcode     (opcode),
    .Out        (out_16),
    .out_valid  (out_valid_16),
    .out_rd     (out_rd_16),
    .zero_flag  (zero_16),
    .carry_flag (carry_16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the opcode table with plain integer arithmetic.
  task automatic model_alu(input int w, input int op, input longint a, input longint b,
                           output longint r, output bit c);
    longint mask, full;
    mask = (longint'(1) << w) - 1;
    c = 1'b0;
    r = 0;
    case (op)
      0:  begin full = a + b; r = full & mask; c = (full >> w) != 0; end
      1:  begin r = (a - b) & mask; c = (a < b); end
      2:  begin full = a * b; r = full & mask; c = (full >> w) != 0; end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = ~a & mask;
      7:  r = ~b & mask;
      8:  r = a;
      9:  r = b;
      10: begin r = a >> 1; c = a[0]; end
      11: begin r = (a << 1) & mask; c = ((a >> (w - 1)) & 1) != 0; end
      12: begin r = (a >> 1) | (a & (longint'(1) << (w - 1))); c = a[0]; end
      13: begin r = ((a << 1) | (a >> (w - 1))) & mask; c = ((a >> (w - 1)) & 1) != 0; end
      default: ;
    endcase
  endtask

  // Drive one instruction into both DUTs; afterwards check the previous one's result.
  task automatic step(input bit v, input int op, input int a, input int b, input int d);
    bit     pv;
    longint r8, r16;
    bit     c8, c16;
    in_valid = v;
    opcode   = 4'(op);
    rs1_8 = 3'(a); rs2_8 = 3'(b); rd_8 = 3'(d);
    rs1_16 = 4'(a); rs2_16 = 4'(b); rd_16 = 4'(d);
    pv = v && (op <= 13);
    r8 = 0; r16 = 0; c8 = 0; c16 = 0;
    if (pv) begin
      model_alu(8, op, m8[a], m8[b], r8, c8);
      model_alu(16, op, m16[a], m16[b], r16, c16);
      m8[d]  = r8;
      m16[d] = r16;
    end
    @(posedge clk);
    #1;
    chk("out_valid8", 32'(out_valid_8), 32'(cur_v));
    chk("out_valid16", 32'(out_valid_16), 32'(cur_v));
    if (cur_v) begin
      chk("out8", 32'(out_8), 32'(cur_r8));
      chk("carry8", 32'(carry_8), 32'(cur_c8));
      chk("zero8", 32'(zero_8), 32'(cur_r8 == 0));
      chk("out_rd8", 32'(out_rd_8), 32'(cur_rd));
      chk("out16", 32'(out_16), 32'(cur_r16));
      chk("carry16", 32'(carry_16), 32'(cur_c16));
      chk("zero16", 32'(zero_16), 32'(cur_r16 == 0));
      chk("out_rd16", 32'(out_rd_16), 32'(cur_rd));
    end
    $display("[TB] t=%0t v=%0d op=%0d rs1=%0d rs2=%0d rd=%0d | out8=%h out16=%h ov=%0d",
             $time, v, op, a, b, d, out_8, out_16, out_valid_8);
    cur_v = pv; cur_rd = d;
    cur_r8 = r8; cur_r16 = r16; cur_c8 = c8; cur_c16 = c16;
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    opcode   = 4'd0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m8[i] = 0;
      m16[i] = 0;
    end
    cur_v = 1'b0;
    chk("rst_out8", 32'(out_8), 32'd0);
    chk("rst_valid8", 32'(out_valid_8), 32'd0);
    chk("rst_rd8", 32'(out_rd_8), 32'd0);
    chk("rst_flags8", 32'({zero_8, carry_8}), 32'd0);
    chk("rst_out16", 32'(out_16), 32'd0);
    chk("rst_valid16", 32'(out_valid_16), 32'd0);
    chk("rst_flags16", 32'({zero_16, carry_16}), 32'd0);
    $display("[TB] t=%0t reset applied for %0d cycle(s)", $time, cycles);
  endtask

  // Builds a constant in register d using R6 = all-ones, R7 = 1; needs R0 == 0.
  task automatic load(input int d, input logic [15:0] val);
    step(1, 6, 0, 0, 6);
    step(1, 1, 0, 6, 7);
    step(1, 8, 0, 0, d);
    for (int i = 15; i >= 0; i--) begin
      step(1, 11, d, 0, d);
      if (val[i]) step(1, 0, d, 7, d);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; opcode = '0;
    rs1_8 = '0; rs2_8 = '0; rd_8 = '0; rs1_16 = '0; rs2_16 = '0; rd_16 = '0;
    cur_v = 0; cur_rd = 0; cur_r8 = 0; cur_r16 = 0; cur_c8 = 0; cur_c16 = 0;
    @(posedge clk);
    #1;
    do_reset(2);

    // MOV-style chain reading freshly written registers
    step(1, 8, 0, 0, 1);
    step(1, 8, 1, 0, 2);
    chk("mov_first_out", 32'(out_8), 32'h00);
    chk("mov_first_zero", 32'(zero_8), 32'd1);
    step(1, 8, 2, 0, 3);
    step(0, 0, 0, 0, 0);

    // ADD / SUB carry and borrow
    load(1, 16'h00F0);
    load(2, 16'h0020);
    step(1, 0, 1, 2, 3);
    step(1, 1, 2, 1, 4);
    chk("add_out", 32'(out_8), 32'h10);
    chk("add_carry", 32'(carry_8), 32'd1);
    step(0, 0, 0, 0, 0);
    chk("sub_out", 32'(out_8), 32'h30);
    chk("sub_borrow", 32'(carry_8), 32'd1);

    // Dependent chain, one per cycle
    load(1, 16'h0003);
    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 2);
    chk("chain0", 32'(out_8), 32'h06);
    step(1, 0, 2, 1, 3);
    chk("chain1", 32'(out_8), 32'h0C);
    step(0, 0, 0, 0, 0);
    chk("chain2", 32'(out_8), 32'h12);
    chk("chain2_valid", 32'(out_valid_8), 32'd1);

    // Two in-flight writers of R5: the younger one must win
    load(1, 16'h0011);
    load(2, 16'h0022);
    step(1, 8, 1, 0, 5);
    step(1, 8, 2, 0, 5);
    step(1, 8, 5, 0, 4);
    step(0, 0, 0, 0, 0);
    chk("same_rd_younger", 32'(out_8), 32'h22);

    // Illegal opcode slot between valid instructions
    step(1, 0, 1, 2, 3);
    step(1, 15, 1, 1, 3);
    step(1, 8, 3, 0, 4);
    chk("illegal_no_valid", 32'(out_valid_8), 32'd0);
    step(0, 0, 0, 0, 0);
    chk("illegal_rd_kept", 32'(out_8), 32'h33);

    // Reset mid-chain discards in-flight work and clears the bank
    step(1, 0, 1, 2, 3);
    step(1, 0, 3, 3, 4);
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1, 8, i, 0, i);
    step(0, 0, 0, 0, 0);

    // Wide-datapath checks on the 16-bit instance
    load(1, 16'h0100);
    load(2, 16'h0100);
    step(1, 2, 1, 2, 3);
    step(0, 0, 0, 0, 0);
    chk("mul16_out", 32'(out_16), 32'h0000);
    chk("mul16_carry", 32'(carry_16), 32'd1);
    chk("mul16_zero", 32'(zero_16), 32'd1);
    load(4, 16'h8001);
    step(1, 13, 4, 0, 5);
    step(0, 0, 0, 0, 0);
    chk("rol16_out", 32'(out_16), 32'h0003);
    chk("rol16_carry", 32'(carry_16), 32'd1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset(1);
      end else begin
        step(1'($urandom_range(0, 9) != 0), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)));
      end
    end
    step(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
